// File: rtl/sa22_pkg.sv
// Shared definitions for the SA22 2x2 matmul sequencer: data width, capture delay,
// FSM state encoding and element slot indices into the packed 4-element buses.
package sa22_pkg;

  localparam int SA22_DW      = 16;
  localparam int SA22_CAP_DLY = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_GAP,
    ST_FEED,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Element slots in {X11,X10,X01,X00}: slot = 2*row + col
  localparam int E00 = 0;
  localparam int E01 = 1;
  localparam int E10 = 2;
  localparam int E11 = 3;

  // Bias slots in {B1,B0}
  localparam int B0 = 0;
  localparam int B1 = 1;

endpackage

// File: rtl/sa22_deskew_cap.sv
// Deskews SA22 bottom-row sums: counts cycles from the t0 strobe, captures each
// C element on its own cycle, and publishes all four at once on the last capture.
module sa22_deskew_cap
  import sa22_pkg::*;
#(
  parameter int DW      = SA22_DW,
  parameter int CAP_DLY = SA22_CAP_DLY
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          t0,
  input  logic [DW-1:0] psum21,
  input  logic [DW-1:0] psum22,
  output logic          cap_last,
  output logic [4*DW-1:0] c_out
);

  localparam int LAST = CAP_DLY + 2;
  localparam int CW   = $clog2(LAST + 2);

  logic            run_q, run_d;
  logic [CW-1:0]   cnt_q, cnt_d, rel;
  logic            active;
  logic [DW-1:0]   c00_q, c00_d, c10_q, c10_d, c01_q, c01_d;
  logic [4*DW-1:0] c_out_q, c_out_d;

  always_comb begin
    rel      = t0 ? '0 : cnt_q;
    active   = t0 | run_q;
    cap_last = active && (rel == CW'(LAST));
    run_d    = run_q;
    cnt_d    = cnt_q;
    c00_d    = c00_q;
    c10_d    = c10_q;
    c01_d    = c01_q;
    c_out_d  = c_out_q;
    if (active) begin
      run_d = ~cap_last;
      cnt_d = rel + 1'b1;
    end
    if (active && rel == CW'(CAP_DLY)) c00_d = psum21;
    if (active && rel == CW'(CAP_DLY + 1)) begin
      c10_d = psum21;
      c01_d = psum22;
    end
    // C11 arrives on the same edge the result is published, so take it straight from the port
    if (cap_last) begin
      c_out_d[E00*DW +: DW] = c00_q;
      c_out_d[E01*DW +: DW] = c01_q;
      c_out_d[E10*DW +: DW] = c10_q;
      c_out_d[E11*DW +: DW] = psum22;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q   <= 1'b0;
      cnt_q   <= '0;
      c00_q   <= '0;
      c10_q   <= '0;
      c01_q   <= '0;
      c_out_q <= '0;
    end else begin
      run_q   <= run_d;
      cnt_q   <= cnt_d;
      c00_q   <= c00_d;
      c10_q   <= c10_d;
      c01_q   <= c01_d;
      c_out_q <= c_out_d;
    end
  end

  assign c_out = c_out_q;

endmodule

// File: rtl/sa22_seq_ctrl.sv
// Runs one 2x2 weight-stationary matmul on SA22: weight load, skewed feed, deskewed capture.
// Optional per-column bias injected through the top partial sums when SA22_BIAS_EN is defined.
module sa22_seq_ctrl
  import sa22_pkg::*;
#(
  parameter int DW      = SA22_DW,
  parameter int CAP_DLY = SA22_CAP_DLY
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            reuse_w,
  input  logic [4*DW-1:0] w_in,
  input  logic [4*DW-1:0] a_in,
`ifdef SA22_BIAS_EN
  input  logic [2*DW-1:0] bias_in,
`endif
  output logic            busy,
  output logic            done,
  output logic [4*DW-1:0] c_out,
  output logic            weight_en,
  output logic [DW-1:0]   weight_in11,
  output logic [DW-1:0]   weight_in12,
  output logic [DW-1:0]   activation_in11,
  output logic [DW-1:0]   activation_in21,
  output logic [DW-1:0]   partial_sum_in11,
  output logic [DW-1:0]   partial_sum_in12,
  input  logic [DW-1:0]   psum21,
  input  logic [DW-1:0]   psum22
);

  state_e          state_q, state_d;
  logic [1:0]      ph_q, ph_d;
  logic [4*DW-1:0] w_q, w_d, a_q, a_d;
  logic            wpres_q, wpres_d;
  logic            t0, cap_last;
  logic [DW-1:0]   bias0, bias1;

`ifdef SA22_BIAS_EN
  logic [2*DW-1:0] b_q, b_d;
  assign bias0 = b_q[B0*DW +: DW];
  assign bias1 = b_q[B1*DW +: DW];
`else
  assign bias0 = '0;
  assign bias1 = '0;
`endif

  always_comb begin
    state_d          = state_q;
    ph_d             = ph_q;
    w_d              = w_q;
    a_d              = a_q;
    wpres_d          = wpres_q;
`ifdef SA22_BIAS_EN
    b_d              = b_q;
`endif
    busy             = 1'b0;
    done             = 1'b0;
    t0               = 1'b0;
    weight_en        = 1'b0;
    weight_in11      = '0;
    weight_in12      = '0;
    activation_in11  = '0;
    activation_in21  = '0;
    partial_sum_in11 = '0;
    partial_sum_in12 = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          w_d  = w_in;
          a_d  = a_in;
          ph_d = '0;
`ifdef SA22_BIAS_EN
          b_d  = bias_in;
`endif
          // Reuse is only honoured once a full load has landed since reset
          state_d = (reuse_w && wpres_q) ? ST_FEED : ST_LOAD_W;
        end
      end
      ST_LOAD_W: begin
        busy      = 1'b1;
        weight_en = 1'b1;
        // Row 1 goes in first so it ends up shifted into the bottom PEs
        if (ph_q == 2'd0) begin
          weight_in11 = w_q[E10*DW +: DW];
          weight_in12 = w_q[E11*DW +: DW];
          ph_d        = 2'd1;
        end else begin
          weight_in11 = w_q[E00*DW +: DW];
          weight_in12 = w_q[E01*DW +: DW];
          ph_d        = 2'd0;
          state_d     = ST_GAP;
        end
      end
      ST_GAP: begin
        busy    = 1'b1;
        wpres_d = 1'b1;
        ph_d    = 2'd0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        busy = 1'b1;
        case (ph_q)
          2'd0: begin
            t0               = 1'b1;
            activation_in11  = a_q[E00*DW +: DW];
            partial_sum_in11 = bias0;
            ph_d             = 2'd1;
          end
          2'd1: begin
            activation_in11  = a_q[E10*DW +: DW];
            activation_in21  = a_q[E01*DW +: DW];
            partial_sum_in11 = bias0;
            partial_sum_in12 = bias1;
            ph_d             = 2'd2;
          end
          default: begin
            activation_in21  = a_q[E11*DW +: DW];
            partial_sum_in12 = bias1;
            ph_d             = 2'd0;
            state_d          = cap_last ? ST_DONE : ST_DRAIN;
          end
        endcase
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (cap_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      w_q     <= '0;
      a_q     <= '0;
      wpres_q <= 1'b0;
`ifdef SA22_BIAS_EN
      b_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      w_q     <= w_d;
      a_q     <= a_d;
      wpres_q <= wpres_d;
`ifdef SA22_BIAS_EN
      b_q     <= b_d;
`endif
    end
  end

  sa22_deskew_cap #(
    .DW      (DW),
    .CAP_DLY (CAP_DLY)
  ) u_cap (
    .clk      (clk),
    .rst      (rst),
    .t0       (t0),
    .psum21   (psum21),
    .psum22   (psum22),
    .cap_last (cap_last),
    .c_out    (c_out)
  );

endmodule
